// File: rtl/vga_bounce_box_if.sv
// Pixel bus between the VGA timing stage, the bouncing-box pixel stage
// and the pin mapper: timing inputs in, registered RGB and sync out.
interface vga_bounce_box_if;
    logic        in_active;
    logic        in_vblank;
    logic [11:0] in_vga_x;
    logic [10:0] in_vga_y;
    logic        in_vga_hs;
    logic        in_vga_vs;
    logic [1:0]  out_video_r;
    logic [1:0]  out_video_g;
    logic [1:0]  out_video_b;
    logic        out_video_hs;
    logic        out_video_vs;

    modport master (
        output in_active, in_vblank, in_vga_x, in_vga_y,
        output in_vga_hs, in_vga_vs,
        input  out_video_r, out_video_g, out_video_b,
        input  out_video_hs, out_video_vs
    );

    modport slave (
        input  in_active, in_vblank, in_vga_x, in_vga_y,
        input  in_vga_hs, in_vga_vs,
        output out_video_r, out_video_g, out_video_b,
        output out_video_hs, out_video_vs
    );
endinterface

// File: rtl/vga_bounce_box.sv
// Bouncing box over a dim checkerboard, one-cycle registered RGB + sync.
// Optional screen-edge border enabled by defining VGA_BOX_BORDER_EN.
module vga_bounce_box #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int BOX_W    = 32,
    parameter int BOX_H    = 32,
    parameter int STEP     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_pause,
    output logic [7:0]       out_frame,
    vga_bounce_box_if.slave  vga
);
    localparam logic [11:0] MAX_X  = 12'(SCREEN_W - BOX_W);
    localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - BOX_H);
    localparam logic [11:0] STEP_X = 12'(STEP);
    localparam logic [10:0] STEP_Y = 11'(STEP);
    localparam logic [11:0] BW     = 12'(BOX_W);
    localparam logic [10:0] BH     = 11'(BOX_H);

    logic [11:0] box_x, nx;
    logic [10:0] box_y, ny;
    logic        dir_x, dir_y, ndx, ndy;
    logic        vblank_q;
    logic        tick;
    logic [1:0]  r_d, g_d, b_d;
    logic        in_box;

    assign tick = vga.in_vblank & ~vblank_q;

    // Subtraction only taken when the guard rules out underflow.
    always_comb begin
        nx  = box_x;
        ndx = dir_x;
        if (dir_x) begin
            if (box_x + STEP_X >= MAX_X) begin
                nx  = MAX_X;
                ndx = 1'b0;
            end else begin
                nx = box_x + STEP_X;
            end
        end else begin
            if (box_x <= STEP_X) begin
                nx  = '0;
                ndx = 1'b1;
            end else begin
                nx = box_x - STEP_X;
            end
        end
    end

    always_comb begin
        ny  = box_y;
        ndy = dir_y;
        if (dir_y) begin
            if (box_y + STEP_Y >= MAX_Y) begin
                ny  = MAX_Y;
                ndy = 1'b0;
            end else begin
                ny = box_y + STEP_Y;
            end
        end else begin
            if (box_y <= STEP_Y) begin
                ny  = '0;
                ndy = 1'b1;
            end else begin
                ny = box_y - STEP_Y;
            end
        end
    end

    assign in_box = (vga.in_vga_x >= box_x) && (vga.in_vga_x < box_x + BW)
                 && (vga.in_vga_y >= box_y) && (vga.in_vga_y < box_y + BH);

`ifdef VGA_BOX_BORDER_EN
    logic on_border;
    assign on_border = (vga.in_vga_x == 12'd0)
                    || (vga.in_vga_x == 12'(SCREEN_W - 1))
                    || (vga.in_vga_y == 11'd0)
                    || (vga.in_vga_y == 11'(SCREEN_H - 1));
`endif

    always_comb begin
        r_d = 2'd0;
        g_d = 2'd0;
        b_d = 2'd0;
        if (!vga.in_active) begin
            r_d = 2'd0;
`ifdef VGA_BOX_BORDER_EN
        end else if (on_border) begin
            r_d = 2'd3;
            g_d = 2'd3;
            b_d = 2'd3;
`endif
        end else if (in_box) begin
            r_d = out_frame[7:6];
            g_d = out_frame[5:4];
            b_d = 2'd3;
        end else if (vga.in_vga_x[5] ^ vga.in_vga_y[5]) begin
            r_d = 2'd1;
            g_d = 2'd1;
            b_d = 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            box_x            <= '0;
            box_y            <= '0;
            dir_x            <= 1'b1;
            dir_y            <= 1'b1;
            out_frame        <= '0;
            vblank_q         <= 1'b0;
            vga.out_video_r  <= '0;
            vga.out_video_g  <= '0;
            vga.out_video_b  <= '0;
            vga.out_video_hs <= 1'b1;
            vga.out_video_vs <= 1'b1;
        end else begin
            vblank_q         <= vga.in_vblank;
            vga.out_video_r  <= r_d;
            vga.out_video_g  <= g_d;
            vga.out_video_b  <= b_d;
            vga.out_video_hs <= vga.in_vga_hs;
            vga.out_video_vs <= vga.in_vga_vs;
            if (tick && !in_pause) begin
                out_frame <= out_frame + 8'd1;
                box_x     <= nx;
                box_y     <= ny;
                dir_x     <= ndx;
                dir_y     <= ndy;
            end
        end
    end
endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed vector bench for vga_bounce_box: pixel table at frame 0,
// then hand-computed bounce, pause and async-reset sequences.
module tb_vga_bounce_box;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_pause = 1'b0;
    logic [7:0] out_frame;
    int         nvec = 0;
    int         nbad = 0;

`ifdef VGA_BOX_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    vga_bounce_box_if vga ();

    vga_bounce_box dut (
        .clock     (clock),
        .reset     (reset),
        .in_pause  (in_pause),
        .out_frame (out_frame),
        .vga       (vga.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        act;
        logic [11:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic [5:0]  rgb;
        logic        ehs;
        logic        evs;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [5:0] checker_c(int x, int y);
        logic [11:0] xv;
        logic [10:0] yv;
        xv = 12'(x);
        yv = 11'(y);
        if (BORDER && (x == 0 || x == 639 || y == 0 || y == 479))
            return 6'b111111;
        return (xv[5] ^ yv[5]) ? 6'b010101 : 6'b000000;
    endfunction

    function automatic logic [5:0] box_c(int x, int y, int f);
        logic [7:0] fv;
        fv = 8'(f);
        if (BORDER && (x == 0 || x == 639 || y == 0 || y == 479))
            return 6'b111111;
        return {fv[7:6], fv[5:4], 2'd3};
    endfunction

    task automatic cmp(string nm, logic [5:0] rgb, logic hs, logic vs);
        logic [5:0] got;
        got = {vga.out_video_r, vga.out_video_g, vga.out_video_b};
        nvec++;
        if (got !== rgb || vga.out_video_hs !== hs || vga.out_video_vs !== vs) begin
            nbad++;
            $display("FAIL %s: got rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b",
                     nm, got, vga.out_video_hs, vga.out_video_vs, rgb, hs, vs);
        end
    endtask

    task automatic cmp_frame(string nm, int f);
        nvec++;
        if (out_frame !== 8'(f)) begin
            nbad++;
            $display("FAIL %s: got frame=%0d, want %0d", nm, out_frame, f);
        end
    endtask

    task automatic drive(logic act, int x, int y, logic hs, logic vs);
        vga.in_active = act;
        vga.in_vblank = 1'b0;
        vga.in_vga_x  = 12'(x);
        vga.in_vga_y  = 11'(y);
        vga.in_vga_hs = hs;
        vga.in_vga_vs = vs;
    endtask

    task automatic probe(string nm, int x, int y, logic [5:0] rgb);
        drive(1'b1, x, y, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        cmp(nm, rgb, 1'b1, 1'b1);
    endtask

    task automatic check_box(string nm, int bx, int by, int f);
        cmp_frame({nm, ".frame"}, f);
        probe({nm, ".tl"}, bx, by, box_c(bx, by, f));
        probe({nm, ".br"}, bx + 31, by + 31, box_c(bx + 31, by + 31, f));
        probe({nm, ".right"}, bx + 32, by, checker_c(bx + 32, by));
        probe({nm, ".below"}, bx, by + 32, checker_c(bx, by + 32));
        if (bx > 0) probe({nm, ".left"}, bx - 1, by, checker_c(bx - 1, by));
        if (by > 0) probe({nm, ".above"}, bx, by - 1, checker_c(bx, by - 1));
    endtask

    task automatic do_tick();
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        vga.in_vblank = 1'b1;
        @(posedge clock);
        #1;
        vga.in_vblank = 1'b0;
        @(posedge clock);
        #1;
    endtask

    int tk = 0;

    task automatic tick_to(int target);
        while (tk < target) begin
            do_tick();
            tk++;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 12'd0,   11'd0,   1'b1, 1'b1,
                    BORDER ? 6'b111111 : 6'b000011, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 12'd31,  11'd31,  1'b0, 1'b1, 6'b000011, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 12'd32,  11'd0,   1'b1, 1'b1,
                    BORDER ? 6'b111111 : 6'b010101, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 12'd0,   11'd32,  1'b1, 1'b1,
                    BORDER ? 6'b111111 : 6'b010101, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 12'd32,  11'd32,  1'b1, 1'b0, 6'b000000, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 12'd5,   11'd5,   1'b0, 1'b0, 6'b000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 12'd64,  11'd1,   1'b1, 1'b1, 6'b000000, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 12'd100, 11'd40,  1'b1, 1'b1, 6'b000000, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 12'd639, 11'd479, 1'b1, 1'b1,
                    BORDER ? 6'b111111 : 6'b010101, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 12'd33,  11'd200, 1'b1, 1'b1, 6'b010101, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 12'd16,  11'd32,  1'b1, 1'b1, 6'b010101, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 12'd31,  11'd0,   1'b1, 1'b1,
                    BORDER ? 6'b111111 : 6'b000011, 1'b1, 1'b1};

        drive(1'b1, 40, 40, 1'b0, 1'b0);
        #12;
        cmp("reset_state", 6'b000000, 1'b1, 1'b1);
        cmp_frame("reset_frame", 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].act, int'(tbl[i].x), int'(tbl[i].y), tbl[i].hs, tbl[i].vs);
            @(posedge clock);
            #1;
            cmp($sformatf("vec%0d", i), tbl[i].rgb, tbl[i].ehs, tbl[i].evs);
        end

        tick_to(1);
        check_box("t1", 2, 2, 1);

        tick_to(196);
        check_box("t196", 392, 392, 196);
        probe("c4_in", 392, 392, 6'b110011);
        probe("c4_out", 424, 392, 6'b010101);

        tick_to(303);
        check_box("t303", 606, 290, 47);
        tick_to(304);
        check_box("x_hit", 608, 288, 48);
        tick_to(305);
        check_box("x_back", 606, 286, 49);

        in_pause = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        check_box("paused", 606, 286, 49);
        in_pause = 1'b0;
        tick_to(306);
        check_box("resume", 604, 284, 50);

        tick_to(448);
        check_box("y_hit", 320, 0, 192);
        tick_to(449);
        check_box("y_back", 318, 2, 193);

        drive(1'b1, 320, 10, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        cmp("pre_reset", box_c(320, 10, 193), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset", 6'b000000, 1'b1, 1'b1);
        cmp_frame("async_frame", 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_box("post_reset", 0, 0, 0);
        probe("border_x0", 0, 200, BORDER ? 6'b111111 : checker_c(0, 200));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
